// File: rtl/telemetry_deframer.sv
// telemetry_deframer: hunts a sync byte and collects an 8-byte LE telemetry payload.
// Define TELEMETRY_CHECKSUM_EN to require a trailing sum-mod-256 checksum byte.
module telemetry_deframer #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_busy,
  output logic [15:0] cpu_freq_mhz,
  output logic [15:0] disk_speed_mbps,
  output logic [15:0] memory_usage,
  output logic [15:0] temperature_c,
  output logic        compute_enable,
  output logic        frame_error,
  output logic [15:0] frames_ok,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam logic [31:0] TMO_CYC =
    32'(TIMEOUT_BYTES * 10 * CLK_FREQ / BAUD);

`ifdef TELEMETRY_CHECKSUM_EN
  localparam int PW = 64;
  typedef enum logic [2:0] {
    IDLE, PAYLOAD, CHECK, COMMIT, ERROR
  } state_t;
`else
  localparam int PW = 56;
  typedef enum logic [2:0] {
    IDLE, PAYLOAD, COMMIT, ERROR
  } state_t;
`endif

  state_t        state_q;
  logic [2:0]    idx_q;
  logic          prev_busy_q;
  logic [31:0]   tmo_q;
  logic [PW-1:0] pay_q;
  logic [63:0]   frame_d;
  logic          strobe;
  logic          tmo_hit;
  logic          go_commit;
  logic          go_error;
`ifdef TELEMETRY_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  assign strobe  = prev_busy_q & ~rx_busy;
  assign tmo_hit = (tmo_q + 32'd1) == TMO_CYC;
  assign busy    = (state_q != IDLE);

  // Without a checksum the last payload byte commits straight off the bus.
`ifdef TELEMETRY_CHECKSUM_EN
  assign frame_d = pay_q;
`else
  assign frame_d = {rx_data, pay_q};
`endif

  always_comb begin
    go_commit = 1'b0;
    go_error  = 1'b0;
    unique case (state_q)
      PAYLOAD: begin
        if (!strobe) begin
          go_error = tmo_hit;
        end else begin
`ifndef TELEMETRY_CHECKSUM_EN
          go_commit = (idx_q == 3'd7);
`endif
        end
      end
`ifdef TELEMETRY_CHECKSUM_EN
      CHECK: begin
        if (strobe) begin
          go_commit = (rx_data == sum_q);
          go_error  = (rx_data != sum_q);
        end else begin
          go_error  = tmo_hit;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      prev_busy_q     <= 1'b0;
      tmo_q           <= '0;
      pay_q           <= '0;
`ifdef TELEMETRY_CHECKSUM_EN
      sum_q           <= '0;
`endif
      cpu_freq_mhz    <= '0;
      disk_speed_mbps <= '0;
      memory_usage    <= '0;
      temperature_c   <= '0;
      compute_enable  <= 1'b0;
      frame_error     <= 1'b0;
      frames_ok       <= '0;
      err_count       <= '0;
    end else begin
      prev_busy_q    <= rx_busy;
      compute_enable <= go_commit;
      frame_error    <= go_error;
      if (go_commit) begin
        cpu_freq_mhz    <= frame_d[15:0];
        disk_speed_mbps <= frame_d[31:16];
        memory_usage    <= frame_d[47:32];
        temperature_c   <= frame_d[63:48];
        frames_ok       <= frames_ok + 16'd1;
      end
      if (go_error && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (strobe && rx_data == SYNC_BYTE) begin
            state_q <= PAYLOAD;
            idx_q   <= '0;
`ifdef TELEMETRY_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        PAYLOAD: begin
          if (go_error) begin
            state_q <= ERROR;
            tmo_q   <= '0;
          end else if (strobe) begin
            tmo_q <= '0;
            idx_q <= idx_q + 3'd1;
            pay_q <= {rx_data, pay_q[PW-1:8]};
`ifdef TELEMETRY_CHECKSUM_EN
            sum_q <= sum_q + rx_data;
            if (idx_q == 3'd7) state_q <= CHECK;
`else
            if (go_commit) state_q <= COMMIT;
`endif
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
`ifdef TELEMETRY_CHECKSUM_EN
        CHECK: begin
          if (go_commit) begin
            state_q <= COMMIT;
            tmo_q   <= '0;
          end else if (go_error) begin
            state_q <= ERROR;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
`endif
        COMMIT: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
        ERROR: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_deframer.sv
// tb_telemetry_deframer: directed frames against a byte-level frame model.
// Follows TELEMETRY_CHECKSUM_EN the same way the design does.
module tb_telemetry_deframer;

  localparam int TMO = 2 * 10 * 500_000 / 100_000;
`ifdef TELEMETRY_CHECKSUM_EN
  localparam int FLEN = 9;
  localparam int NGOOD = 10;
  localparam int E3 = 1;
`else
  localparam int FLEN = 8;
  localparam int NGOOD = 9;
  localparam int E3 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_busy;
  logic [15:0] cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c;
  logic        compute_enable, frame_error, busy;
  logic [15:0] frames_ok;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail = 0;
  int ce_pulses = 0;

  telemetry_deframer #(
    .CLK_FREQ(500_000), .BAUD(100_000),
    .SYNC_BYTE(8'hA5), .TIMEOUT_BYTES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_busy(rx_busy),
    .cpu_freq_mhz(cpu_freq_mhz),
    .disk_speed_mbps(disk_speed_mbps),
    .memory_usage(memory_usage),
    .temperature_c(temperature_c),
    .compute_enable(compute_enable),
    .frame_error(frame_error),
    .frames_ok(frames_ok),
    .err_count(err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model state
  logic        m_prev = 1'b0;
  logic        m_in = 1'b0;
  int          m_idle = 0;
  logic [7:0]  m_q [$];
  logic [15:0] m_f [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
  logic        m_ce = 1'b0, m_fe = 1'b0;
  logic [15:0] m_ok = '0;
  logic [7:0]  m_err = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_error();
    m_fe = 1'b1;
    if (m_err != 8'd255) m_err++;
  endtask

  function automatic logic m_good();
`ifdef TELEMETRY_CHECKSUM_EN
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(m_q[i]);
    return (s % 256) == int'(m_q[8]);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step();
    logic stb;
    if (!rst_n) begin
      m_prev = 0; m_in = 0; m_idle = 0; m_q.delete();
      m_f = '{16'd0, 16'd0, 16'd0, 16'd0};
      m_ce = 0; m_fe = 0; m_ok = 0; m_err = 0;
      return;
    end
    m_ce = 0;
    m_fe = 0;
    stb = m_prev && !rx_busy;
    m_prev = rx_busy;
    if (stb) begin
      if (!m_in) begin
        if (rx_data == 8'hA5) begin
          m_in = 1; m_idle = 0; m_q.delete();
        end
      end else begin
        m_q.push_back(rx_data);
        m_idle = 0;
        if (m_q.size() == FLEN) begin
          m_in = 0;
          if (m_good()) begin
            for (int k = 0; k < 4; k++) m_f[k] = {m_q[2*k+1], m_q[2*k]};
            m_ok++;
            m_ce = 1;
          end else begin
            m_error();
          end
        end
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_in = 0;
        m_error();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (compute_enable === 1'b1) ce_pulses++;
    if (!rst_n) begin
      chk("rst_fields", {cpu_freq_mhz, disk_speed_mbps}, 0);
      chk("rst_fields2", {memory_usage, temperature_c}, 0);
      chk("rst_misc", {frames_ok, err_count, compute_enable,
                       frame_error, busy}, 0);
    end else begin
      chk("ce", 32'(compute_enable), 32'(m_ce));
      chk("fe", 32'(frame_error), 32'(m_fe));
      chk("busy", 32'(busy), 32'(m_in | m_ce | m_fe));
      chk("cpu", 32'(cpu_freq_mhz), 32'(m_f[0]));
      chk("disk", 32'(disk_speed_mbps), 32'(m_f[1]));
      chk("mem", 32'(memory_usage), 32'(m_f[2]));
      chk("temp", 32'(temperature_c), 32'(m_f[3]));
      chk("frames_ok", 32'(frames_ok), 32'(m_ok));
      chk("err_count", 32'(err_count), 32'(m_err));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_busy = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  logic [7:0] good [10] = '{8'hA5, 8'h94, 8'h11, 8'hD0, 8'h07,
                            8'h00, 8'h40, 8'h46, 8'h00, 8'h02};

  task automatic send_good();
    for (int i = 0; i < NGOOD; i++) send_byte(good[i]);
  endtask

  task automatic pin_fields(input string tag);
    chk({tag, "_cpu"}, 32'(cpu_freq_mhz), 4500);
    chk({tag, "_disk"}, 32'(disk_speed_mbps), 2000);
    chk({tag, "_mem"}, 32'(memory_usage), 16384);
    chk({tag, "_temp"}, 32'(temperature_c), 70);
  endtask

  initial begin
    rst_n = 1'b0; rx_busy = 1'b0; rx_data = 8'h00;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_pulses", 32'(ce_pulses), 0);

    send_good();
    @(negedge clk);
    pin_fields("good");
    chk("good_ok", 32'(frames_ok), 1);
    chk("good_err", 32'(err_count), 0);
    chk("good_pulses", 32'(ce_pulses), 1);

`ifdef TELEMETRY_CHECKSUM_EN
    for (int i = 0; i < 9; i++) send_byte(good[i]);
    send_byte(8'h03);
    @(negedge clk);
    pin_fields("badck");
    chk("badck_err", 32'(err_count), 1);
    chk("badck_pulses", 32'(ce_pulses), 1);
`endif

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_good();
    @(negedge clk);
    chk("hunt_ok", 32'(frames_ok), 2);
    chk("hunt_err", 32'(err_count), 32'(E3));
    chk("hunt_pulses", 32'(ce_pulses), 2);

    for (int i = 0; i < 4; i++) send_byte(good[i]);
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    chk("tmo_err", 32'(err_count), 32'(E3 + 1));
    chk("tmo_busy", 32'(busy), 0);
    send_good();
    @(negedge clk);
    chk("tmo_next_ok", 32'(frames_ok), 3);

    for (int i = 0; i < 5; i++) send_byte(good[i]);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 5; i < NGOOD; i++) send_byte(good[i]);
    @(negedge clk);
    chk("rst_drop_ok", 32'(frames_ok), 0);
    chk("rst_drop_busy", 32'(busy), 0);

`ifdef TELEMETRY_CHECKSUM_EN
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 9; i++) send_byte(good[i]);
      send_byte(8'h03);
    end
`else
    for (int n = 0; n < 260; n++) begin
      send_byte(8'hA5);
      repeat (TMO + 5) @(posedge clk);
    end
`endif
    @(negedge clk);
    chk("sat_err", 32'(err_count), 255);
    chk("sat_ok", 32'(frames_ok), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
